// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter among byte producers
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    [NUM_REQ]          requester i has a byte pending
//   req_data     [NUM_REQ*DATA_W]   byte of requester i at [i*DATA_W +: DATA_W]
//   req_ready    [NUM_REQ]          one-hot accept, only ever high in IDLE
//   tx_start     one-cycle launch pulse to the UART TX FSM
//   tx_data      [DATA_W]           byte latched at acceptance
//   tx_done      one-cycle completion pulse from the UART TX FSM
//   busy         high whenever the scheduler is not IDLE
//   grant_id     index of the last accepted requester
//   timeout_err  one-cycle pulse when tx_done does not arrive in time
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_err
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    state_t            after_frame;
    logic [ID_W-1:0]   ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [ID_W-1:0]   win_hi;
    logic [ID_W-1:0]   win_lo;
    logic              hi_found;
    logic              any_valid;
    logic [ID_W-1:0]   winner;
    logic              accept;

    // Round-robin pick: lowest valid index at or above ptr, otherwise wrap
    // to the lowest valid index overall. Scanning downward leaves the lowest
    // match in each variable.
    always_comb begin
        win_hi    = '0;
        win_lo    = '0;
        hi_found  = 1'b0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_lo    = ID_W'(i);
                any_valid = 1'b1;
                if (ID_W'(i) >= ptr) begin
                    win_hi   = ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        winner = hi_found ? win_hi : win_lo;
    end

    assign after_frame = (GAP_CYCLES == 0) ? IDLE : GAP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                // rst gate keeps ready low while the async reset is held
                if (any_valid && !rst) begin
                    req_ready  = NUM_REQ'(1) << winner;
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_start   = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done takes priority over a timeout landing in the same cycle
                if (tx_done) begin
                    state_next = after_frame;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
                    timeout_err = 1'b1;
                    state_next  = after_frame;
                end
            end
            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            tx_data  <= '0;
            grant_id <= '0;
            gap_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            if (accept) begin
                tx_data  <= req_data[int'(winner)*DATA_W +: DATA_W];
                grant_id <= winner;
                ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end

            // gap counter holds the remaining GAP cycles, loaded on entry
            if (state != GAP && state_next == GAP) begin
                gap_cnt <= GAP_W'(GAP_CYCLES);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            // wait counter is 0 in the first WAIT_DONE cycle
            if (state == WAIT_DONE && state_next == WAIT_DONE) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [1:0]  a_valid;
    logic [15:0] a_data;
    logic [1:0]  a_ready;
    logic        a_start;
    logic [7:0]  a_txd;
    logic        a_done;
    logic        a_busy;
    logic        a_gid;
    logic        a_terr;

    logic [1:0]  b_valid;
    logic [15:0] b_data;
    logic [1:0]  b_ready;
    logic        b_start;
    logic [7:0]  b_txd;
    logic        b_done;
    logic        b_busy;
    logic        b_gid;
    logic        b_terr;

    uart_tx_scheduler #(
        .NUM_REQ(2), .DATA_W(8), .GAP_CYCLES(16), .TIMEOUT_CYCLES(50)
    ) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .tx_start(a_start), .tx_data(a_txd), .tx_done(a_done),
        .busy(a_busy), .grant_id(a_gid), .timeout_err(a_terr)
    );

    uart_tx_scheduler #(
        .NUM_REQ(2), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .tx_start(b_start), .tx_data(b_txd), .tx_done(b_done),
        .busy(b_busy), .grant_id(b_gid), .timeout_err(b_terr)
    );

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ready;
        logic       exp_gid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[9];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        while (a_busy && n < 200) begin
            tick();
            n++;
        end
        chk(name, a_busy, 0);
    endtask

    task automatic run_txn_a(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [1:0] er, input logic eg, input logic [7:0] ed,
                             input string tag);
        wait_idle_a($sformatf("%s_idle", tag));
        a_valid = v;
        a_data  = {d1, d0};
        #3;
        chk($sformatf("%s_ready", tag), a_ready, er);
        tick();
        a_valid = 2'b00;
        chk($sformatf("%s_start", tag), a_start, 1);
        chk($sformatf("%s_gid", tag), a_gid, eg);
        chk($sformatf("%s_data", tag), a_txd, ed);
        tick();
        chk($sformatf("%s_start_off", tag), a_start, 0);
        repeat (3) tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic early;

        vt[0] = '{2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11};
        vt[1] = '{2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h22};
        vt[2] = '{2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 8'h11};
        vt[3] = '{2'b11, 8'h11, 8'h22, 2'b10, 1'b1, 8'h22};
        vt[4] = '{2'b01, 8'h3C, 8'h00, 2'b01, 1'b0, 8'h3C};
        vt[5] = '{2'b01, 8'h5A, 8'h00, 2'b01, 1'b0, 8'h5A};
        vt[6] = '{2'b10, 8'h00, 8'hC3, 2'b10, 1'b1, 8'hC3};
        vt[7] = '{2'b10, 8'h00, 8'h7E, 2'b10, 1'b1, 8'h7E};
        vt[8] = '{2'b11, 8'h99, 8'h66, 2'b01, 1'b0, 8'h99};

        rst     = 1'b1;
        a_valid = 2'b11;
        a_data  = 16'h2211;
        a_done  = 1'b0;
        b_valid = 2'b00;
        b_data  = 16'h0000;
        b_done  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_start", a_start, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_gid", a_gid, 0);
        chk("rst_txd", a_txd, 0);
        chk("rst_terr", a_terr, 0);
        rst     = 1'b0;
        a_valid = 2'b00;

        for (int i = 0; i < 9; i++) begin
            run_txn_a(vt[i].valid, vt[i].d0, vt[i].d1, vt[i].exp_ready,
                      vt[i].exp_gid, vt[i].exp_data, $sformatf("rr%0d", i));
        end

        // single requester; tx_done during START and GAP must be ignored
        wait_idle_a("single_idle");
        a_valid = 2'b01;
        a_data  = 16'h00A5;
        #3;
        chk("single_ready", a_ready, 2'b01);
        tick();
        a_valid = 2'b00;
        a_done  = 1'b1;
        chk("single_start", a_start, 1);
        chk("single_txd", a_txd, 8'hA5);
        chk("single_busy", a_busy, 1);
        chk("single_ready_off", a_ready, 0);
        tick();
        a_done = 1'b0;
        chk("single_start_off", a_start, 0);
        repeat (25) tick();
        chk("done_in_start_ignored", a_busy, 1);
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("gap_busy%0d", k), a_busy, 1);
            a_done = (k == 5);
            tick();
        end
        a_done = 1'b0;
        chk("gap_end_idle", a_busy, 0);
        chk("single_txd_hold", a_txd, 8'hA5);

        // timeout after 50 WAIT_DONE cycles
        wait_idle_a("to_idle");
        a_valid = 2'b10;
        a_data  = 16'h4D00;
        #3;
        chk("to_ready", a_ready, 2'b10);
        tick();
        a_valid = 2'b00;
        chk("to_txd", a_txd, 8'h4D);
        tick();
        early = 1'b0;
        for (int k = 1; k < 50; k++) begin
            if (a_terr !== 1'b0) early = 1'b1;
            tick();
        end
        chk("to_no_early", early, 0);
        chk("to_pulse", a_terr, 1);
        tick();
        chk("to_pulse_end", a_terr, 0);
        chk("to_gap_busy", a_busy, 1);
        run_txn_a(2'b11, 8'h44, 8'h88, 2'b01, 1'b0, 8'h44, "after_to");

        // tx_done on the 50th cycle wins over timeout
        wait_idle_a("dw_idle");
        a_valid = 2'b01;
        a_data  = 16'h00E7;
        #3;
        chk("dw_ready", a_ready, 2'b01);
        tick();
        a_valid = 2'b00;
        tick();
        repeat (49) tick();
        a_done = 1'b1;
        #1;
        chk("dw_no_terr", a_terr, 0);
        tick();
        a_done = 1'b0;
        repeat (15) tick();
        chk("dw_gap_busy", a_busy, 1);
        tick();
        chk("dw_gap_done", a_busy, 0);

        // reset during WAIT_DONE with ptr at 1
        a_valid = 2'b01;
        a_data  = 16'h00B6;
        #3;
        tick();
        a_valid = 2'b00;
        tick();
        tick();
        a_valid = 2'b11;
        a_data  = 16'h2211;
        rst     = 1'b1;
        #1;
        chk("mrst_ready", a_ready, 0);
        chk("mrst_start", a_start, 0);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_txd", a_txd, 0);
        chk("mrst_gid", a_gid, 0);
        chk("mrst_terr", a_terr, 0);
        tick();
        rst = 1'b0;
        #3;
        chk("mrst_next_ready", a_ready, 2'b01);
        tick();
        a_valid = 2'b00;
        chk("mrst_next_gid", a_gid, 0);
        chk("mrst_next_txd", a_txd, 8'h11);
        chk("mrst_next_start", a_start, 1);

        // zero-gap instance: accept right after the edge that sampled tx_done
        b_valid = 2'b10;
        b_data  = 16'h5500;
        #3;
        chk("g0_ready", b_ready, 2'b10);
        tick();
        b_valid = 2'b01;
        b_data  = 16'h5533;
        chk("g0_start", b_start, 1);
        chk("g0_txd", b_txd, 8'h55);
        chk("g0_ready_start", b_ready, 0);
        tick();
        chk("g0_ready_wait", b_ready, 0);
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        chk("g0_idle", b_busy, 0);
        chk("g0_ready_next", b_ready, 2'b01);
        tick();
        b_valid = 2'b00;
        chk("g0_start2", b_start, 1);
        chk("g0_txd2", b_txd, 8'h33);
        chk("g0_gid2", b_gid, 0);
        chk("g0_terr", b_terr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter among `NUM_REQ` byte producers (e.g. core MMIO store path, debug monitor). It accepts one byte at a time from the winning requester through a valid/ready handshake, launches the transmitter with a one-cycle `tx_start` pulse, and waits for its `tx_done` pulse. It then enforces a programmable inter-frame idle gap before re-arbitrating. The block sits between the requesters and the UART TX FSM/datapath.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8).
- `DATA_W`, 8, byte width presented to the transmitter.
- `GAP_CYCLES`, 16, idle clock cycles between `tx_done` and the next arbitration (0 = none).
- `TIMEOUT_CYCLES`, 0, max cycles waiting for `tx_done` before abort (0 = disabled).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte pending; held until accepted.
- `req_data`  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]; stable while valid.
- `req_ready`  out  NUM_REQ  one-hot; transfer for requester i occurs on the edge where `req_valid[i] && req_ready[i]`.
- `tx_start`  out  1  one-cycle launch pulse to the UART TX FSM.
- `tx_data`  out  DATA_W  registered byte to transmit; stable from `tx_start` until the next acceptance.
- `tx_done`  in  1  one-cycle completion pulse from the UART TX FSM.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_id`  out  clog2(NUM_REQ) (min 1)  index of the last accepted requester.
- `timeout_err`  out  1  one-cycle pulse on transmit timeout.

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE: if any `req_valid`, winner = first valid index at or after round-robin pointer `ptr`, scanning upward with wrap. `req_ready[winner]` = 1 combinationally in the same cycle; all other bits 0. On that edge: `tx_data` <= winner's byte, `grant_id` <= winner, `ptr` <= (winner+1) mod NUM_REQ, state -> START. With no valid: stay IDLE, `req_ready` = 0.
- START: `tx_start` = 1 for exactly this cycle; -> WAIT_DONE.
- WAIT_DONE: on `tx_done` = 1 -> GAP (or IDLE if GAP_CYCLES = 0). If TIMEOUT_CYCLES ≠ 0 and the wait counter reaches TIMEOUT_CYCLES with no `tx_done`: pulse `timeout_err`, -> GAP (or IDLE).
- GAP: down-counter loaded with GAP_CYCLES on entry; -> IDLE when it expires after exactly GAP_CYCLES cycles in GAP.
- `req_ready` is 0 in every state except IDLE; requesters never lose a byte.
- `tx_done` outside WAIT_DONE is ignored.
- Counters saturate-free: gap counter width clog2(GAP_CYCLES+1), timeout counter width clog2(TIMEOUT_CYCLES+1); both cleared on state entry.

## Timing
- Reset values: state IDLE, `ptr` 0, `tx_data` 0, `grant_id` 0, `tx_start` 0, `busy` 0, `timeout_err` 0, counters 0. `req_ready` = 0 while `rst` is high.
- Acceptance at edge N (IDLE) -> `tx_start` high during cycle N+1 -> WAIT_DONE from N+2.
- `tx_done` sampled high at edge M -> GAP from M+1. The next acceptance is possible at edge M+GAP_CYCLES+1, or at edge M+1 when GAP_CYCLES = 0.
- Timeout fires on the TIMEOUT_CYCLES-th WAIT_DONE cycle. If `tx_done` arrives in that same cycle, done wins and `timeout_err` stays 0.
- `rst` asserted mid-frame: immediate return to IDLE and `tx_start` low. Any byte already accepted is dropped; requesters re-present after reset.
- Throughput bound: one byte per (3 + transmitter frame time + GAP_CYCLES) cycles.

## Test plan
- Single requester, NUM_REQ=2, req 0 sends 0xA5 -> `req_ready[0]` for 1 cycle, `tx_start` 1 cycle later with `tx_data`=0xA5, `busy` stays high until GAP_CYCLES=16 cycles after `tx_done`.
- Both valid continuously with 0x11 / 0x22 -> grants alternate 0,1,0,1, `grant_id` follows, and no requester is granted twice in a row.
- `tx_done` pulsed during START and GAP -> ignored; state advances only on `tx_done` in WAIT_DONE.
- TIMEOUT_CYCLES=50, `tx_done` never sent -> `timeout_err` 1-cycle pulse 50 cycles into WAIT_DONE, then GAP, then IDLE with the next request serviced. Repeat with `tx_done` on cycle 50 -> no error.
- GAP_CYCLES=0 -> acceptance on the edge directly after the WAIT_DONE edge that sampled `tx_done`.
- `rst` pulsed during WAIT_DONE -> all outputs at reset values and `ptr`=0; the next grant goes to requester 0 when both are valid.
